freq_gate_ctrl: RTL and testbench

- Timing controller for the 6-digit BCD frequency counter: generates the clear pulse, the gate window (enable) and the result latch strobe from a stable reference clock.
- Latches the counter's 24-bit BCD value after each gate window and holds it for display.
- Supports continuous (auto-repeat) and single-shot measurement modes. Sits between the reference-clock divider and the counter/display path.

---
 rtl/freq_gate_ctrl.sv | 156 +++++++++++++++
 tb/tb_freq_gate_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/freq_gate_ctrl.sv
// Gate-window sequencer for the 6-digit BCD frequency counter: clear, gate, settle,
// latch and hold phases timed from the reference clock, with continuous and single-shot modes.
module freq_gate_ctrl #(
    parameter int CNT_W         = 24,
    parameter int CLR_CYCLES    = 2,
    parameter int GATE_CYCLES   = 1000,
    parameter int SETTLE_CYCLES = 2,
    parameter int HOLD_CYCLES   = 500
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             RUN,
    input  logic             ONESHOT,
    input  logic [CNT_W-1:0] CNT_Q,
    output logic             CNT_ENA,
    output logic             CNT_CLR,
    output logic [CNT_W-1:0] RESULT,
    output logic             RESULT_VALID,
    output logic             BUSY,
    output logic [7:0]       MEAS_COUNT
);

    // state  | meaning
    // IDLE   | waiting for RUN or ONESHOT
    // CLEAR  | counter held in clear
    // GATE   | counter enabled (gate window)
    // SETTLE | gate closed, letting CNT_Q settle across domains
    // LATCH  | sample CNT_Q into RESULT
    // HOLD   | display hold before next measurement
    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_GATE, S_SETTLE, S_LATCH, S_HOLD
    } state_t;

    localparam int MAX_AB  = (CLR_CYCLES > GATE_CYCLES) ? CLR_CYCLES : GATE_CYCLES;
    localparam int MAX_CD  = (SETTLE_CYCLES > HOLD_CYCLES) ? SETTLE_CYCLES : HOLD_CYCLES;
    localparam int MAX_CYC = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int TMR_W   = $clog2(MAX_CYC) + 1;

    localparam logic [TMR_W-1:0] CLR_LOAD    = TMR_W'(CLR_CYCLES - 1);
    localparam logic [TMR_W-1:0] GATE_LOAD   = TMR_W'(GATE_CYCLES - 1);
    localparam logic [TMR_W-1:0] SETTLE_LOAD = TMR_W'(SETTLE_CYCLES - 1);
    localparam logic [TMR_W-1:0] HOLD_LOAD   = TMR_W'(HOLD_CYCLES - 1);

    state_t             state_q, state_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic               single_q, single_d;
    logic [CNT_W-1:0]   result_q, result_d;
    logic [7:0]         meas_count_q, meas_count_d;
    logic               cnt_ena_q, cnt_ena_d;
    logic               cnt_clr_q, cnt_clr_d;
    logic               result_valid_q, result_valid_d;
    logic               busy_q, busy_d;
    logic               abort;
    logic               tmr_done;

    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q;
        single_d     = single_q;
        result_d     = result_q;
        meas_count_d = meas_count_q;
        abort        = !single_q && !RUN;
        tmr_done     = (timer_q == '0);

        case (state_q)
            S_IDLE: begin
                if (RUN) begin
                    state_d  = S_CLEAR;
                    timer_d  = CLR_LOAD;
                    single_d = 1'b0;
                end else if (ONESHOT) begin
                    state_d  = S_CLEAR;
                    timer_d  = CLR_LOAD;
                    single_d = 1'b1;
                end
            end
            S_CLEAR, S_GATE, S_SETTLE: begin
                // Continuous runs abort only before the latch point.
                if (abort) begin
                    state_d = S_IDLE;
                    timer_d = '0;
                end else if (tmr_done) begin
                    case (state_q)
                        S_CLEAR: begin state_d = S_GATE;   timer_d = GATE_LOAD;   end
                        S_GATE:  begin state_d = S_SETTLE; timer_d = SETTLE_LOAD; end
                        default: begin state_d = S_LATCH;  timer_d = '0;          end
                    endcase
                end else begin
                    timer_d = timer_q - TMR_W'(1);
                end
            end
            S_LATCH: begin
                result_d     = CNT_Q;
                meas_count_d = meas_count_q + 8'd1;
                state_d      = S_HOLD;
                timer_d      = HOLD_LOAD;
            end
            S_HOLD: begin
                if (tmr_done) begin
                    if (!single_q && RUN) begin
                        state_d = S_CLEAR;
                        timer_d = CLR_LOAD;
                    end else begin
                        state_d  = S_IDLE;
                        timer_d  = '0;
                        single_d = 1'b0;
                    end
                end else begin
                    timer_d = timer_q - TMR_W'(1);
                end
            end
            default: begin
                state_d  = S_IDLE;
                timer_d  = '0;
                single_d = 1'b0;
            end
        endcase

        cnt_clr_d      = (state_d == S_CLEAR);
        cnt_ena_d      = (state_d == S_GATE);
        busy_d         = (state_d != S_IDLE);
        result_valid_d = (state_q == S_LATCH);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q        <= S_IDLE;
            timer_q        <= '0;
            single_q       <= 1'b0;
            result_q       <= '0;
            meas_count_q   <= '0;
            cnt_ena_q      <= 1'b0;
            cnt_clr_q      <= 1'b0;
            result_valid_q <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            timer_q        <= timer_d;
            single_q       <= single_d;
            result_q       <= result_d;
            meas_count_q   <= meas_count_d;
            cnt_ena_q      <= cnt_ena_d;
            cnt_clr_q      <= cnt_clr_d;
            result_valid_q <= result_valid_d;
            busy_q         <= busy_d;
        end
    end

    assign CNT_ENA      = cnt_ena_q;
    assign CNT_CLR      = cnt_clr_q;
    assign RESULT       = result_q;
    assign RESULT_VALID = result_valid_q;
    assign BUSY         = busy_q;
    assign MEAS_COUNT   = meas_count_q;

endmodule

// File: tb/tb_freq_gate_ctrl.sv
// Bench for freq_gate_ctrl: directed scenarios plus random RUN/ONESHOT traffic, compared
// each cycle against a position-in-measurement reference model.
module tb_freq_gate_ctrl;

    localparam int CNT_W  = 24;
    localparam int CLR    = 2;
    localparam int GATE   = 10;
    localparam int SETTLE = 2;
    localparam int HOLD   = 3;
    localparam int LATCH_POS = CLR + GATE + SETTLE;
    localparam int PERIOD    = CLR + GATE + SETTLE + 1 + HOLD;

    logic             CLK = 1'b0;
    logic             RST_N = 1'b0;
    logic             RUN = 1'b0;
    logic             ONESHOT = 1'b0;
    logic [CNT_W-1:0] CNT_Q = '0;
    logic             CNT_ENA, CNT_CLR, RESULT_VALID, BUSY;
    logic [CNT_W-1:0] RESULT;
    logic [7:0]       MEAS_COUNT;

    freq_gate_ctrl #(
        .CNT_W(CNT_W), .CLR_CYCLES(CLR), .GATE_CYCLES(GATE),
        .SETTLE_CYCLES(SETTLE), .HOLD_CYCLES(HOLD)
    ) dut (
        .CLK(CLK), .RST_N(RST_N), .RUN(RUN), .ONESHOT(ONESHOT), .CNT_Q(CNT_Q),
        .CNT_ENA(CNT_ENA), .CNT_CLR(CNT_CLR), .RESULT(RESULT),
        .RESULT_VALID(RESULT_VALID), .BUSY(BUSY), .MEAS_COUNT(MEAS_COUNT)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_err = 0;

    // reference model: measurement viewed as a position 0..PERIOD-1 since CLEAR entry
    bit               m_active;
    int               m_pos;
    bit               m_single;
    logic [CNT_W-1:0] m_result;
    bit               m_valid;
    logic [7:0]       m_count;

    int cyc;
    int clr_rises[$];
    int ena_cycles;
    int valid_pulses;
    logic prev_clr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, obs, exp_v);
        end
    endtask

    task automatic model_reset();
        m_active = 0; m_pos = 0; m_single = 0;
        m_result = '0; m_valid = 0; m_count = '0;
    endtask

    task automatic model_step(input bit run, input bit os, input logic [CNT_W-1:0] q);
        m_valid = 0;
        if (!m_active) begin
            if (run) begin
                m_active = 1; m_pos = 0; m_single = 0;
            end else if (os) begin
                m_active = 1; m_pos = 0; m_single = 1;
            end
        end else if (!m_single && !run && m_pos < LATCH_POS) begin
            m_active = 0;
        end else if (m_pos == LATCH_POS) begin
            m_result = q;
            m_valid  = 1;
            m_count  = m_count + 8'd1;
            m_pos++;
        end else if (m_pos == PERIOD - 1) begin
            if (!m_single && run) m_pos = 0;
            else begin
                m_active = 0; m_single = 0;
            end
        end else begin
            m_pos++;
        end
    endtask

    task automatic compare_all();
        bit e_clr, e_ena;
        e_clr = m_active && (m_pos < CLR);
        e_ena = m_active && (m_pos >= CLR) && (m_pos < CLR + GATE);
        chk("cnt_clr", 32'(CNT_CLR), 32'(e_clr));
        chk("cnt_ena", 32'(CNT_ENA), 32'(e_ena));
        chk("busy", 32'(BUSY), 32'(m_active));
        chk("result", 32'(RESULT), 32'(m_result));
        chk("result_valid", 32'(RESULT_VALID), 32'(m_valid));
        chk("meas_count", 32'(MEAS_COUNT), 32'(m_count));
        chk("clr_ena_excl", 32'(CNT_CLR & CNT_ENA), 32'd0);
    endtask

    // one clock: DUT and model see the same sampled inputs, outputs checked 1 time unit later
    task automatic step();
        @(posedge CLK);
        model_step(RUN, ONESHOT, CNT_Q);
        #1;
        cyc++;
        if (CNT_CLR && !prev_clr) clr_rises.push_back(cyc);
        prev_clr = CNT_CLR;
        if (CNT_ENA) ena_cycles++;
        if (RESULT_VALID) valid_pulses++;
        compare_all();
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic reset_dut();
        RST_N = 1'b0;
        #1;
        model_reset();
        compare_all();
        @(posedge CLK);
        @(posedge CLK);
        #1;
        RST_N = 1'b1;
        prev_clr = 1'b0;
        clr_rises.delete();
        ena_cycles = 0;
        valid_pulses = 0;
    endtask

    initial begin
        cyc = 0;
        prev_clr = 1'b0;
        model_reset();

        // continuous run, fixed count value
        reset_dut();
        chk("reset_count", 32'(MEAS_COUNT), 32'd0);
        RUN = 1'b1; CNT_Q = 24'h000123;
        steps(2 * PERIOD + 2);
        chk("clr_period", 32'(clr_rises.size() >= 2 ? clr_rises[1] - clr_rises[0] : 0), 32'(PERIOD));
        chk("two_meas", 32'(MEAS_COUNT), 32'd2);
        chk("result_123", 32'(RESULT), 32'h000123);

        // single shot with RUN low
        reset_dut();
        RUN = 1'b0; CNT_Q = 24'h999999; ONESHOT = 1'b1;
        step();
        ONESHOT = 1'b0;
        steps(PERIOD + 4);
        chk("os_ena_cycles", 32'(ena_cycles), 32'(GATE));
        chk("os_valid_pulses", 32'(valid_pulses), 32'd1);
        chk("os_result", 32'(RESULT), 32'h999999);
        chk("os_busy", 32'(BUSY), 32'd0);
        chk("os_count", 32'(MEAS_COUNT), 32'd1);

        // RUN dropped at gate cycle 5
        reset_dut();
        RUN = 1'b1; CNT_Q = 24'h000456;
        steps(1 + CLR + 4);
        RUN = 1'b0;
        steps(PERIOD);
        chk("abort_valid", 32'(valid_pulses), 32'd0);
        chk("abort_count", 32'(MEAS_COUNT), 32'd0);
        chk("abort_result", 32'(RESULT), 32'd0);

        // RUN dropped during HOLD
        reset_dut();
        RUN = 1'b1; CNT_Q = 24'h004321;
        steps(1 + LATCH_POS + 2);
        RUN = 1'b0;
        steps(PERIOD);
        chk("hold_drop_valid", 32'(valid_pulses), 32'd1);
        chk("hold_drop_busy", 32'(BUSY), 32'd0);

        // async reset mid-gate, restart afterwards
        reset_dut();
        RUN = 1'b1; CNT_Q = 24'h000777;
        steps(1 + CLR + 3);
        #2;
        RST_N = 1'b0;
        #1;
        model_reset();
        chk("async_ena", 32'(CNT_ENA), 32'd0);
        compare_all();
        @(posedge CLK);
        #1;
        RST_N = 1'b1;
        prev_clr = 1'b0;
        steps(PERIOD + 3);

        // wrap of the measurement counter
        reset_dut();
        RUN = 1'b1; CNT_Q = 24'h012345;
        steps(256 * PERIOD + 1);
        chk("wrap_count", 32'(MEAS_COUNT), 32'd0);

        // random traffic
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 39) == 0) RUN = ~RUN;
            ONESHOT = ($urandom_range(0, 7) == 0);
            CNT_Q   = CNT_W'($urandom);
            if ($urandom_range(0, 1499) == 0) begin
                reset_dut();
            end
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
